// File: rtl/fp_int_mac_bit_serial.sv
// Bit-serial FP16 x INT MAC: one weight bit per valid cycle, LSB first, sign bit last.
// Optional subnormal decode is enabled with FP_INT_MAC_SUBNORMAL_EN; otherwise e=0 flushes to zero.
module fp_int_mac_bit_serial #(
   parameter int ACT_WIDTH = 16,
   parameter int ACC_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid,
   input  logic [3:0]           precision,
   input  logic                 set,
   input  logic [ACT_WIDTH-1:0] act,
   input  logic                 w,
   input  logic [4:0]           exp_min,
   input  logic [ACC_WIDTH-1:0] fixed_point_acc,
   output logic [4:0]           exp_out,
   output logic [ACC_WIDTH-1:0] fixed_point_out,
   output logic                 done
);

   logic [ACC_WIDTH-1:0]        acc;
   logic [3:0]                  cnt;
   logic signed [ACC_WIDTH-1:0] aligned;
   logic [3:0]                  nbits;
   logic [4:0]                  exp_r;

   logic [4:0]                  e_raw;
   logic [4:0]                  e_eff;
   logic [10:0]                 mant;
   logic [ACC_WIDTH+31:0]       wide;
   logic [ACC_WIDTH-1:0]        mag;
   logic signed [ACC_WIDTH-1:0] decoded;
   logic signed [ACC_WIDTH-1:0] cur_aligned;
   logic [3:0]                  cur_n;
   logic [ACC_WIDTH-1:0]        term;
   logic                        last;

   // The wide intermediate keeps left shifts of up to 30 exact before truncating to ACC_WIDTH.
   always_comb begin
      e_raw = act[14:10];
      e_eff = (e_raw == 5'd31) ? 5'd30 : e_raw;
`ifdef FP_INT_MAC_SUBNORMAL_EN
      if (e_raw == 5'd0) begin
         mant  = {1'b0, act[9:0]};
         e_eff = 5'd1;
      end else begin
         mant  = {1'b1, act[9:0]};
      end
`else
      mant = (e_raw == 5'd0) ? 11'd0 : {1'b1, act[9:0]};
`endif
      wide        = '0;
      wide[10:0]  = mant;
      if (e_eff >= exp_r) wide = wide << (e_eff - exp_r);
      else                wide = wide >> (exp_r - e_eff);
      mag         = wide[ACC_WIDTH-1:0];
      decoded     = act[15] ? -signed'(mag) : signed'(mag);
      cur_aligned = (cnt == 4'd0) ? decoded : aligned;
      cur_n       = (cnt != 4'd0) ? nbits : ((precision == 4'd0) ? 4'd1 : precision);
      last        = (cnt == cur_n - 4'd1);
      term        = cur_aligned << cnt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         cnt     <= '0;
         aligned <= '0;
         nbits   <= 4'd1;
         exp_r   <= '0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (set) begin
            acc   <= fixed_point_acc;
            exp_r <= exp_min;
            cnt   <= '0;
         end else if (valid) begin
            if (cnt == 4'd0) begin
               aligned <= decoded;
               nbits   <= cur_n;
            end
            // Bit N-1 carries negative weight in two's complement.
            if (w) acc <= last ? (acc - term) : (acc + term);
            if (last) begin
               cnt  <= '0;
               done <= 1'b1;
            end else begin
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

   assign fixed_point_out = acc;
   assign exp_out         = exp_r;

endmodule

// File: tb/tb_fp_int_mac_bit_serial.sv
// Self-checking bench for fp_int_mac_bit_serial: directed cases plus randomized operations against a multiply-based model.
module tb_fp_int_mac_bit_serial;
   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [3:0]  precision;
   logic        set;
   logic [15:0] act;
   logic        w;
   logic [4:0]  exp_min;
   logic [31:0] fixed_point_acc;
   logic [4:0]  exp_out;
   logic [31:0] fixed_point_out;
   logic        done;

   int tests = 0;
   int fails = 0;
   logic [31:0] m_acc;
   logic [4:0]  m_exp;

   fp_int_mac_bit_serial #(.ACT_WIDTH(16), .ACC_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .valid(valid), .precision(precision), .set(set),
      .act(act), .w(w), .exp_min(exp_min), .fixed_point_acc(fixed_point_acc),
      .exp_out(exp_out), .fixed_point_out(fixed_point_out), .done(done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Activation value scaled to 2^exp_ref, truncated toward zero, wrapped to 32 bits.
   function automatic logic [31:0] ref_aligned(input logic [15:0] a, input logic [4:0] er);
      int e;
      longint mag;
      logic [31:0] m32;
      e = int'(a[14:10]);
      if (e == 31) e = 30;
`ifdef FP_INT_MAC_SUBNORMAL_EN
      if (e == 0) begin
         mag = longint'(a[9:0]);
         e = 1;
      end else begin
         mag = 1024 + longint'(a[9:0]);
      end
`else
      if (e == 0) return 32'd0;
      mag = 1024 + longint'(a[9:0]);
`endif
      if (e >= int'(er)) mag = mag * (longint'(1) << (e - int'(er)));
      else               mag = mag / (longint'(1) << (int'(er) - e));
      m32 = mag[31:0];
      return a[15] ? -m32 : m32;
   endfunction

   function automatic int wval(input logic [15:0] bits, input int n);
      int v = 0;
      for (int i = 0; i < n; i++)
         if (bits[i]) v += (i == n - 1) ? -(1 << i) : (1 << i);
      return v;
   endfunction

   task automatic do_set(input logic [31:0] a, input logic [4:0] e);
      set = 1'b1; valid = 1'b0; fixed_point_acc = a; exp_min = e;
      tick;
      set = 1'b0;
      m_acc = a; m_exp = e;
      chk("set_acc", fixed_point_out, a);
      chk("set_exp", exp_out, {27'd0, e});
   endtask

   // Non-first bits drive junk act/precision to confirm both are latched at bit 0.
   task automatic run_op(input logic [15:0] a, input logic [3:0] prec, input logic [15:0] bits,
                         input int gap_after, input int gap_len);
      int n;
      n = (prec == 4'd0) ? 1 : int'(prec);
      m_acc = m_acc + ref_aligned(a, m_exp) * wval(bits, n);
      for (int i = 0; i < n; i++) begin
         valid = 1'b1; w = bits[i];
         act = (i == 0) ? a : 16'($urandom);
         precision = (i == 0) ? prec : 4'($urandom);
         tick;
         chk("done", {31'd0, done}, {31'd0, (i == n - 1)});
         if (i == gap_after) begin
            valid = 1'b0;
            repeat (gap_len) begin
               w = 1'($urandom);
               act = 16'($urandom);
               tick;
               chk("gap_done", {31'd0, done}, 32'd0);
            end
         end
      end
      valid = 1'b0;
      chk("result", fixed_point_out, m_acc);
   endtask

   initial begin
      rst = 1'b0; valid = 1'b0; set = 1'b0; w = 1'b0; precision = 4'd0;
      act = 16'd0; exp_min = 5'd0; fixed_point_acc = 32'd0;
      m_acc = 32'd0; m_exp = 5'd0;
      repeat (3) begin
         tick;
         chk("rst_out", fixed_point_out, 32'd0);
         chk("rst_exp", {27'd0, exp_out}, 32'd0);
         chk("rst_done", {31'd0, done}, 32'd0);
      end
      rst = 1'b1;
      tick;

      do_set(32'd2, 5'd16);
      run_op(16'h4569, 4'd4, 16'b0101, -1, 0);
      chk("pos_lit", fixed_point_out, 32'd13852);
      chk("pos_exp", {27'd0, exp_out}, 32'd16);
      tick;
      chk("done_clear", {31'd0, done}, 32'd0);

      do_set(32'd2, 5'd16);
      run_op(16'h4569, 4'd4, 16'b1111, -1, 0);
      chk("neg_lit", fixed_point_out, 32'hFFFFF530);

      do_set(32'd0, 5'd16);
      run_op(16'hBE80, 4'd4, 16'b0011, -1, 0);
      chk("rshift_lit", fixed_point_out, -32'sd2496);

      do_set(32'd0, 5'd16);
      run_op(16'h4AAA, 4'd4, 16'b0001, 0, 2);
      chk("pause_lit", fixed_point_out, 32'd6824);
      run_op(16'hBE80, 4'd4, 16'b0001, -1, 0);
      chk("b2b_lit", fixed_point_out, 32'd5992);

      run_op(16'h4569, 4'd0, 16'b0001, -1, 0);
      chk("prec0_lit", fixed_point_out, 32'd5992 - 32'd2770);

      // set overrides a valid bit mid-operation; the next bit restarts with fresh act.
      do_set(32'd100, 5'd16);
      valid = 1'b1; precision = 4'd4; act = 16'h4569;
      for (int i = 0; i < 2; i++) begin
         w = 1'b1;
         tick;
      end
      set = 1'b1; w = 1'b1; fixed_point_acc = 32'd555; exp_min = 5'd16; act = 16'h7BFF;
      tick;
      set = 1'b0; valid = 1'b0;
      chk("setv_acc", fixed_point_out, 32'd555);
      chk("setv_done", {31'd0, done}, 32'd0);
      m_acc = 32'd555; m_exp = 5'd16;
      run_op(16'h4569, 4'd4, 16'b0001, -1, 0);
      chk("setv_lit", fixed_point_out, 32'd3325);

      // Asynchronous reset mid-operation.
      valid = 1'b1; precision = 4'd6; act = 16'h5555; w = 1'b1;
      tick;
      tick;
      #2 rst = 1'b0;
      #1;
      chk("arst_out", fixed_point_out, 32'd0);
      chk("arst_exp", {27'd0, exp_out}, 32'd0);
      valid = 1'b0;
      tick;
      rst = 1'b1;
      m_acc = 32'd0; m_exp = 5'd0;
      run_op(16'h3C00, 4'd3, 16'b011, -1, 0);

      for (int k = 0; k < 60; k++) begin
         if (k % 8 == 0) do_set($urandom, 5'($urandom_range(0, 31)));
         run_op(16'($urandom), 4'($urandom_range(0, 15)), 16'($urandom),
                $urandom_range(0, 15), $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
